// File: rtl/plic_lite_if.sv
// AHB-lite slave-side bus bundle for plic_lite.
// The master drives address/control/write data; the slave returns read data and response.
interface plic_lite_if;
    logic        HSELx;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        output HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/plic_lite.sv
// Single-context platform interrupt controller: per-source gateway, priority, enable,
// threshold and claim/complete, exposed as a zero-wait-state AHB-lite slave.
module plic_lite #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    plic_lite_if.slave         bus,
    output logic               irq_external
);
    localparam int unsigned ID_W = $clog2(NUM_SRC + 1);

    // Word indices (byte offset >> 2) of the fixed registers
    localparam logic [7:0] W_PENDING = 8'h20;
    localparam logic [7:0] W_ENABLE  = 8'h40;
    localparam logic [7:0] W_THRESH  = 8'h80;
    localparam logic [7:0] W_CLAIM   = 8'h81;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_t;

    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    gw_state_t          r_state     [1:NUM_SRC];
    gw_state_t          w_state_nxt [1:NUM_SRC];
    logic [PRIO_W-1:0]  r_prio      [1:NUM_SRC];
    logic [NUM_SRC:0]   r_enable;
    logic [PRIO_W-1:0]  r_thr;
    logic               r_wr_valid;
    logic [7:0]         r_wr_addr;
    logic [2:0]         r_wr_size;

    logic [NUM_SRC:0]   w_pending;
    logic [ID_W-1:0]    w_best_id;
    logic [PRIO_W-1:0]  w_best_prio;
    logic               w_accept;
    logic               w_rd;
    logic               w_claim;
    logic               w_commit;
    logic               w_complete;
    logic [7:0]         w_raddr;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign bus.HREADY = 1'b1;
    assign bus.HRESP  = 2'b00;

    assign w_accept   = bus.HSELx & bus.HTRANS[1] & bus.HREADY;
    assign w_rd       = w_accept & ~bus.HWRITE;
    assign w_raddr    = bus.HADDR[9:2];
    assign w_claim    = w_rd && (w_raddr == W_CLAIM) && (w_best_id != '0);
    assign w_commit   = r_wr_valid && (r_wr_size == 3'b010);
    assign w_complete = w_commit && (r_wr_addr == W_CLAIM);
    assign w_unused   = ^{bus.HBURST, bus.HMASTLOCK, bus.HADDR[31:10], bus.HADDR[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src_irq;
            r_sync2 <= r_sync1;
        end
    end

    // Gateway FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                r_state[i] <= GW_IDLE;
            end
        end else begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Gateway FSM: next state; claim and complete on the same edge are independent
    always_comb begin
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                GW_IDLE:    if (r_sync2[i-1]) w_state_nxt[i] = GW_PENDING;
                GW_PENDING: if (w_claim && (w_best_id == ID_W'(i))) w_state_nxt[i] = GW_CLAIMED;
                GW_CLAIMED: if (w_complete && (bus.HWDATA == 32'(i))) w_state_nxt[i] = GW_IDLE;
                default:    w_state_nxt[i] = GW_IDLE;
            endcase
        end
    end

    // Gateway FSM: outputs
    always_comb begin
        w_pending = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            w_pending[i] = (r_state[i] == GW_PENDING);
        end
    end

    // Strict '>' keeps the lowest ID on equal priority
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (w_pending[i] && r_enable[i] && (r_prio[i] > r_thr) && (r_prio[i] > w_best_prio)) begin
                w_best_id   = ID_W'(i);
                w_best_prio = r_prio[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_size  <= '0;
        end else begin
            r_wr_valid <= w_accept & bus.HWRITE;
            if (w_accept) begin
                r_wr_addr <= bus.HADDR[9:2];
                r_wr_size <= bus.HSIZE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                r_prio[i] <= '0;
            end
            r_enable <= '0;
            r_thr    <= '0;
        end else if (w_commit) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                if ((r_wr_addr[7:5] == 3'b000) && (r_wr_addr[4:0] == 5'(i))) begin
                    r_prio[i] <= bus.HWDATA[PRIO_W-1:0];
                end
            end
            if (r_wr_addr == W_ENABLE) begin
                r_enable <= {bus.HWDATA[NUM_SRC:1], 1'b0};
            end
            if (r_wr_addr == W_THRESH) begin
                r_thr <= bus.HWDATA[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_raddr[7:5] == 3'b000) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                if (w_raddr[4:0] == 5'(i)) begin
                    w_rdata[PRIO_W-1:0] = r_prio[i];
                end
            end
        end else begin
            case (w_raddr)
                W_PENDING: w_rdata[NUM_SRC:0]  = w_pending;
                W_ENABLE:  w_rdata[NUM_SRC:0]  = r_enable;
                W_THRESH:  w_rdata[PRIO_W-1:0] = r_thr;
                W_CLAIM:   w_rdata[ID_W-1:0]   = w_best_id;
                default:   w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.HRDATA   <= '0;
            irq_external <= 1'b0;
        end else begin
            if (w_rd) begin
                bus.HRDATA <= w_rdata;
            end
            irq_external <= (w_best_id != '0);
        end
    end
endmodule

// File: tb/tb_plic_lite.sv
// Randomised and directed bench for plic_lite against a set-based reference model
// of the gateway states, priorities, enables and threshold.
module tb_plic_lite;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src_irq = '0;
    logic       irq_external;

    plic_lite_if bus();

    plic_lite #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_irq      (src_irq),
        .bus          (bus),
        .irq_external (irq_external)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model
    int       m_prio    [1:8];
    bit [8:0] m_en;
    int       m_thr;
    bit       m_pend    [1:8];
    bit       m_claimed [1:8];

    function automatic void model_reset();
        for (int id = 1; id <= 8; id++) begin
            m_prio[id] = 0; m_pend[id] = 0; m_claimed[id] = 0;
        end
        m_en = '0; m_thr = 0;
    endfunction

    function automatic void model_settle();
        for (int id = 1; id <= 8; id++)
            if (!m_claimed[id] && src_irq[id-1]) m_pend[id] = 1;
    endfunction

    function automatic int model_best();
        int b = 0;
        for (int p = 7; p > m_thr; p--)
            for (int id = 1; id <= 8; id++)
                if (b == 0 && m_pend[id] && m_en[id] && m_prio[id] == p) b = id;
        return b;
    endfunction

    function automatic int model_claim();
        int b = model_best();
        if (b != 0) begin m_pend[b] = 0; m_claimed[b] = 1; end
        return b;
    endfunction

    function automatic void model_complete(input int id);
        if (id >= 1 && id <= 8 && m_claimed[id]) m_claimed[id] = 0;
    endfunction

    function automatic logic [31:0] pend_mask();
        logic [31:0] m;
        m = '0;
        for (int id = 1; id <= 8; id++) if (m_pend[id]) m[id] = 1'b1;
        return m;
    endfunction

    // Bus helpers
    task automatic bus_idle();
        bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
        bus.HBURST = 3'b000; bus.HMASTLOCK = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
    endtask

    task automatic bus_write_sz(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        @(negedge clk);
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a; bus.HSIZE = sz;
        @(negedge clk);
        bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d; bus.HSIZE = 3'b010;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_write_sz(a, d, 3'b010);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
        @(negedge clk);
        bus.HSELx = 1'b0; bus.HTRANS = 2'b00;
        d = bus.HRDATA;
    endtask

    task automatic set_prio(input int id, input int p);
        bus_write(32'(4 * id), 32'(p)); m_prio[id] = p;
    endtask

    task automatic set_en(input logic [8:0] v);
        bus_write(32'h100, {23'b0, v}); m_en = v & 9'h1FE;
    endtask

    task automatic set_thr(input int t);
        bus_write(32'h200, 32'(t)); m_thr = t;
    endtask

    task automatic complete(input int id);
        bus_write(32'h204, 32'(id)); model_complete(id);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; src_irq = '0; bus_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0; model_reset();
    endtask

    task automatic check_claim(input string name);
        logic [31:0] got; int exp;
        exp = model_claim();
        bus_read(32'h204, got);
        n_total++;
        if (got !== 32'(exp)) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else n_pass++;
    endtask

    task automatic check_pending(input string name);
        logic [31:0] got;
        bus_read(32'h080, got);
        n_total++;
        if (got !== pend_mask()) $display("FAIL %s: got %0h expected %0h", name, got, pend_mask());
        else n_pass++;
    endtask

    task automatic check_irq(input string name);
        logic exp;
        exp = (model_best() != 0);
        n_total++;
        if (irq_external !== exp) $display("FAIL %s: got %b expected %b", name, irq_external, exp);
        else n_pass++;
    endtask

    // Tests
    task automatic test_reset();
        logic [31:0] got;
        rst = 1'b1; bus_idle(); src_irq = '0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.HRDATA !== 32'h0) $display("FAIL reset_hrdata: got %0h expected 0", bus.HRDATA); else n_pass++;
        n_total++; if (irq_external !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_external); else n_pass++;
        n_total++; if (bus.HREADY !== 1'b1) $display("FAIL reset_hready: got %b expected 1", bus.HREADY); else n_pass++;
        n_total++; if (bus.HRESP !== 2'b00) $display("FAIL reset_hresp: got %b expected 0", bus.HRESP); else n_pass++;
        rst = 1'b0; model_reset();
        bus_read(32'h100, got);
        n_total++; if (got !== {23'b0, m_en}) $display("FAIL reset_enable: got %0h expected %0h", got, m_en); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        set_prio(3, 2); set_en(9'h008); set_thr(1);
        @(negedge clk); src_irq[2] = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_total++; if (irq_external !== 1'b0) $display("FAIL basic_irq_early: got %b expected 0", irq_external); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (irq_external !== 1'b1) $display("FAIL basic_irq_latency: got %b expected 1", irq_external); else n_pass++;
        model_settle();
        check_claim("basic_claim");
        @(negedge clk);
        check_irq("basic_irq_after_claim");
        src_irq[2] = 1'b0; settle();
        complete(3); settle(); model_settle();
        check_pending("basic_pending_after_complete");
    endtask

    task automatic test_priority();
        do_reset();
        set_prio(2, 5); set_prio(5, 5); set_prio(6, 7); set_en(9'h1FE); set_thr(0);
        src_irq = 8'hFF; settle(); model_settle();
        check_irq("prio_irq");
        for (int k = 0; k < 4; k++) check_claim("prio_claim_seq");
    endtask

    task automatic test_threshold();
        do_reset();
        set_prio(1, 4); set_en(9'h002); set_thr(4);
        src_irq[0] = 1'b1; settle(); model_settle();
        check_irq("thr_masked");
        set_thr(3);
        n_total++; if (irq_external !== 1'b0) $display("FAIL thr_write_not_yet: got %b expected 0", irq_external); else n_pass++;
        @(posedge clk); #1;
        check_irq("thr_next_cycle");
    endtask

    task automatic test_complete_ignored();
        do_reset();
        set_prio(4, 3); set_en(9'h010); set_thr(0);
        src_irq[3] = 1'b1; settle(); model_settle();
        complete(4); settle(); model_settle();
        check_pending("cmpl_unclaimed_ignored");
        complete(0); complete(9); settle();
        check_claim("cmpl_claim4");
        complete(4); settle(); model_settle();
        check_pending("cmpl_repend");
        check_irq("cmpl_irq_reassert");
    endtask

    task automatic test_back_to_back();
        logic [31:0] got1, got2; int e1, e2;
        do_reset();
        set_prio(1, 1); set_prio(2, 2); set_prio(3, 1); set_en(9'h00E); set_thr(0);
        src_irq = 8'b0000_0011; settle(); model_settle();
        @(negedge clk);
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h204;
        e1 = model_claim();
        @(negedge clk);
        got1 = bus.HRDATA; e2 = model_claim();
        @(negedge clk);
        bus_idle(); got2 = bus.HRDATA;
        n_total++; if (got1 !== 32'(e1)) $display("FAIL b2b_claim1: got %0d expected %0d", got1, e1); else n_pass++;
        n_total++; if (got2 !== 32'(e2)) $display("FAIL b2b_claim2: got %0d expected %0d", got2, e2); else n_pass++;
        src_irq = 8'b0000_0100; settle(); model_settle();
        @(negedge clk);
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'h204;
        @(negedge clk);
        bus.HWRITE = 1'b0; bus.HWDATA = 32'd2;
        e1 = model_claim(); model_complete(2);
        @(negedge clk);
        bus_idle(); got1 = bus.HRDATA;
        n_total++; if (got1 !== 32'(e1)) $display("FAIL b2b_claim_with_complete: got %0d expected %0d", got1, e1); else n_pass++;
        src_irq[1] = 1'b1; settle(); model_settle();
        check_pending("b2b_complete_applied");
        check_irq("b2b_irq");
    endtask

    task automatic test_reset_mid_claim();
        logic [31:0] got; int e;
        do_reset();
        set_prio(1, 1); set_en(9'h002);
        src_irq[0] = 1'b1; settle(); model_settle();
        @(negedge clk);
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h204;
        e = model_claim();
        @(posedge clk); #1;
        n_total++; if (bus.HRDATA !== 32'(e)) $display("FAIL rstmid_data: got %0d expected %0d", bus.HRDATA, e); else n_pass++;
        #2 rst = 1'b1; #1;
        n_total++; if (bus.HRDATA !== 32'h0) $display("FAIL rstmid_hrdata: got %0h expected 0", bus.HRDATA); else n_pass++;
        n_total++; if (irq_external !== 1'b0) $display("FAIL rstmid_irq: got %b expected 0", irq_external); else n_pass++;
        bus_idle();
        @(negedge clk); rst = 1'b0; model_reset();
        check_claim("rstmid_claim_after");
    endtask

    task automatic test_regs();
        logic [31:0] got;
        do_reset();
        bus_write_sz(32'h200, 32'd5, 3'b000);
        bus_read(32'h200, got);
        n_total++; if (got !== 32'(m_thr)) $display("FAIL regs_byte_write: got %0h expected %0h", got, m_thr); else n_pass++;
        set_prio(2, 32'hFFFF_FFFF & 7);
        bus_write(32'h008, 32'hFFFF_FFFF);
        bus_read(32'h008, got);
        n_total++; if (got !== 32'h7) $display("FAIL regs_prio_upper: got %0h expected 7", got); else n_pass++;
        bus_read(32'h000, got);
        n_total++; if (got !== 32'h0) $display("FAIL regs_prio0: got %0h expected 0", got); else n_pass++;
        bus_write(32'h300, 32'hDEAD_BEEF);
        bus_read(32'h300, got);
        n_total++; if (got !== 32'h0) $display("FAIL regs_unmapped: got %0h expected 0", got); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] got; logic [8:0] en;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int id = 1; id <= 8; id++) set_prio(id, int'($urandom_range(0, 7)));
            en = 9'($urandom_range(0, 511));
            set_en(en); set_thr(int'($urandom_range(0, 3)));
            bus_read(32'h100, got);
            n_total++; if (got !== {23'b0, m_en}) $display("FAIL rand_enable: got %0h expected %0h", got, m_en); else n_pass++;
            src_irq = 8'($urandom); settle(); model_settle();
            check_irq("rand_irq");
            check_pending("rand_pending");
            for (int k = 0; k < 9; k++) check_claim("rand_claim");
            for (int id = 1; id <= 8; id++)
                if (m_claimed[id] && $urandom_range(0, 1) == 1) complete(id);
            settle(); model_settle();
            src_irq = 8'($urandom); settle(); model_settle();
            check_pending("rand_pending2");
            check_irq("rand_irq2");
        end
    endtask

    initial begin
        bus_idle();
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_threshold();
        test_complete_ignored();
        test_back_to_back();
        test_reset_mid_claim();
        test_regs();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
